// File: rtl/march_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : march_bist_ctrl
// Brief    : March C- BIST controller for a 2^ADDR_W x DATA_W synchronous
//            single-port SRAM, with functional-port pass-through when idle.
//            Optional macro BIST_ERRCNT_EN: run to completion and count
//            every mismatching read instead of aborting on the first one.
// Revision : 1.0 - initial release
// ============================================================================
module march_bist_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] func_addr,
    input  logic [DATA_W-1:0] func_din,
    input  logic              func_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic              sram_we,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [2:0]        fail_elem,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic [ADDR_W:0]   err_count
);

    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] c_ONES     = '1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_M0    = 4'd1,
        S_M1    = 4'd2,
        S_M2    = 4'd3,
        S_M3    = 4'd4,
        S_M4    = 4'd5,
        S_M5    = 4'd6,
        S_DRAIN = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_phase;
    logic              r_cmp_pend;
    logic [DATA_W-1:0] r_cmp_exp;
    logic [2:0]        r_cmp_elem;
    logic [ADDR_W-1:0] r_cmp_addr;
    logic              r_fail;
    logic [2:0]        r_fail_elem;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_exp;
    logic [DATA_W-1:0] r_fail_got;

    logic              w_busy;
    logic              w_march;
    logic              w_rw;
    logic              w_down;
    logic              w_next_down;
    logic              w_rd;
    logic              w_bist_we;
    logic [DATA_W-1:0] w_bist_din;
    logic [DATA_W-1:0] w_exp;
    logic [2:0]        w_elem;
    logic              w_elem_end;
    logic              w_start_ok;
    logic              w_mismatch;
    logic              w_abort;

    assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_mismatch = r_cmp_pend && (sram_dout != r_cmp_exp);

`ifdef BIST_ERRCNT_EN
    assign w_abort = 1'b0;
`else
    assign w_abort = w_mismatch;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Per-element decode: direction, op per phase, write data, expected read data.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_march     = 1'b0;
        w_rw        = 1'b0;
        w_down      = 1'b0;
        w_next_down = 1'b0;
        w_rd        = 1'b0;
        w_bist_we   = 1'b0;
        w_bist_din  = '0;
        w_exp       = '0;
        w_elem      = 3'd0;
        w_elem_end  = 1'b0;
        unique case (r_state)
            S_M0: begin
                w_busy = 1'b1; w_march = 1'b1; w_elem = 3'd0;
                w_bist_we = 1'b1;
            end
            S_M1: begin
                w_busy = 1'b1; w_march = 1'b1; w_rw = 1'b1; w_elem = 3'd1;
                w_bist_we = r_phase; w_rd = !r_phase; w_bist_din = c_ONES;
            end
            S_M2: begin
                w_busy = 1'b1; w_march = 1'b1; w_rw = 1'b1; w_elem = 3'd2;
                w_bist_we = r_phase; w_rd = !r_phase; w_exp = c_ONES;
                w_next_down = 1'b1;
            end
            S_M3: begin
                w_busy = 1'b1; w_march = 1'b1; w_rw = 1'b1; w_elem = 3'd3;
                w_down = 1'b1; w_next_down = 1'b1;
                w_bist_we = r_phase; w_rd = !r_phase; w_bist_din = c_ONES;
            end
            S_M4: begin
                w_busy = 1'b1; w_march = 1'b1; w_rw = 1'b1; w_elem = 3'd4;
                w_down = 1'b1; w_next_down = 1'b1;
                w_bist_we = r_phase; w_rd = !r_phase; w_exp = c_ONES;
            end
            S_M5: begin
                w_busy = 1'b1; w_march = 1'b1; w_elem = 3'd5;
                w_down = 1'b1; w_rd = 1'b1;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
            end
            default: begin
            end
        endcase

        w_elem_end = w_march && (!w_rw || r_phase) &&
                     (r_addr == (w_down ? {ADDR_W{1'b0}} : {ADDR_W{1'b1}}));

        unique case (r_state)
            S_IDLE, S_DONE: if (w_start_ok) w_state_nxt = S_M0;
            S_M0:    if (w_elem_end) w_state_nxt = S_M1;
            S_M1:    if (w_elem_end) w_state_nxt = S_M2;
            S_M2:    if (w_elem_end) w_state_nxt = S_M3;
            S_M3:    if (w_elem_end) w_state_nxt = S_M4;
            S_M4:    if (w_elem_end) w_state_nxt = S_M5;
            S_M5:    if (w_elem_end) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = S_DONE;
        end
    end

    // Address/phase sequencing, compare pipeline and first-fail capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_phase     <= 1'b0;
            r_cmp_pend  <= 1'b0;
            r_cmp_exp   <= '0;
            r_cmp_elem  <= 3'd0;
            r_cmp_addr  <= '0;
            r_fail      <= 1'b0;
            r_fail_elem <= 3'd0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_got  <= '0;
        end else if (w_start_ok) begin
            r_addr      <= '0;
            r_phase     <= 1'b0;
            r_cmp_pend  <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_elem <= 3'd0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_got  <= '0;
        end else begin
            if (w_abort) begin
                r_cmp_pend <= 1'b0;
            end else if (w_busy) begin
                if (w_rw && !r_phase) begin
                    r_phase <= 1'b1;
                end else begin
                    r_phase <= 1'b0;
                    if (w_elem_end) begin
                        r_addr <= w_next_down ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
                    end else if (w_down) begin
                        r_addr <= r_addr - c_ADDR_ONE;
                    end else begin
                        r_addr <= r_addr + c_ADDR_ONE;
                    end
                end
                r_cmp_pend <= w_rd;
                r_cmp_exp  <= w_exp;
                r_cmp_elem <= w_elem;
                r_cmp_addr <= r_addr;
            end
            if (w_mismatch && !r_fail) begin
                r_fail      <= 1'b1;
                r_fail_elem <= r_cmp_elem;
                r_fail_addr <= r_cmp_addr;
                r_fail_exp  <= r_cmp_exp;
                r_fail_got  <= sram_dout;
            end
        end
    end

`ifdef BIST_ERRCNT_EN
    localparam logic [ADDR_W:0] c_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    logic [ADDR_W:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_start_ok) begin
            r_err_cnt <= '0;
        end else if (w_mismatch && r_err_cnt != {(ADDR_W+1){1'b1}}) begin
            r_err_cnt <= r_err_cnt + c_CNT_ONE;
        end
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = '0;
`endif

    assign sram_addr = w_busy ? r_addr     : func_addr;
    assign sram_din  = w_busy ? w_bist_din : func_din;
    assign sram_we   = w_busy ? w_bist_we  : func_we;

    assign busy      = w_busy;
    assign done      = (r_state == S_DONE);
    assign fail      = r_fail;
    assign fail_elem = r_fail_elem;
    assign fail_addr = r_fail_addr;
    assign fail_exp  = r_fail_exp;
    assign fail_got  = r_fail_got;

endmodule
`default_nettype wire

// File: tb/tb_march_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_march_bist_ctrl
// Brief    : Self-checking bench for march_bist_ctrl with a faultable SRAM
//            model and a loop-level March C- reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_march_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] func_addr;
    logic [3:0] func_din;
    logic       func_we;
    logic [7:0] sram_addr;
    logic [3:0] sram_din;
    logic       sram_we;
    logic [3:0] sram_dout;
    logic       busy, done, fail;
    logic [2:0] fail_elem;
    logic [7:0] fail_addr;
    logic [3:0] fail_exp, fail_got;
    logic [8:0] err_count;

    int checks   = 0;
    int failures = 0;

    // SRAM fault configuration
    bit         stuck_on  = 1'b0;
    logic [7:0] stuck_addr = 8'h00;
    logic [3:0] stuck_mask = 4'h0;
    logic [3:0] stuck_val  = 4'h0;
    bit         alias_on  = 1'b0;
    logic [7:0] alias_src = 8'h00;
    logic [7:0] alias_dst = 8'h00;

    logic [3:0] mem [256];
    logic [3:0] model_mem [256];

    march_bist_ctrl #(.ADDR_W(8), .DATA_W(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .func_addr(func_addr), .func_din(func_din), .func_we(func_we),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_we(sram_we),
        .sram_dout(sram_dout),
        .busy(busy), .done(done), .fail(fail),
        .fail_elem(fail_elem), .fail_addr(fail_addr),
        .fail_exp(fail_exp), .fail_got(fail_got), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] fault_store(input logic [7:0] a, input logic [3:0] d);
        if (stuck_on && a == stuck_addr) return (d & ~stuck_mask) | (stuck_val & stuck_mask);
        return d;
    endfunction

    // Synchronous single-port SRAM, registered read data
    always @(posedge clk) begin
        if (sram_we) begin
            mem[sram_addr] <= fault_store(sram_addr, sram_din);
            if (alias_on && sram_addr == alias_src)
                mem[alias_dst] <= fault_store(alias_dst, sram_din);
        end else begin
            sram_dout <= mem[sram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input int a, input logic [3:0] d);
        model_mem[a] = fault_store(a[7:0], d);
        if (alias_on && a[7:0] == alias_src) model_mem[alias_dst] = fault_store(alias_dst, d);
    endtask

    // Walks the March C- element list op by op over a copy of the SRAM.
    task automatic model_run(output int done_edge, output bit mf, output logic [2:0] me,
                             output logic [7:0] ma, output logic [3:0] mx, output logic [3:0] mg,
                             output int mec);
        int k, last_rd, a;
        bit stop;
        logic [3:0] exp_v, got_v;
        model_mem = mem;
        k = 0; last_rd = 0; stop = 1'b0;
        mf = 1'b0; me = 3'd0; ma = 8'h00; mx = 4'h0; mg = 4'h0; mec = 0;
        for (int e = 0; e < 6 && !stop; e++) begin
            for (int i = 0; i < 256 && !stop; i++) begin
                a = (e >= 3) ? 255 - i : i;
                if (e != 0) begin
                    exp_v = (e == 2 || e == 4) ? 4'hF : 4'h0;
                    got_v = model_mem[a];
                    last_rd = k;
                    if (got_v !== exp_v) begin
                        if (mec < 511) mec++;
                        if (!mf) begin
                            mf = 1'b1; me = e[2:0]; ma = a[7:0]; mx = exp_v; mg = got_v;
                        end
`ifndef BIST_ERRCNT_EN
                        stop = 1'b1;
`endif
                    end
                    k++;
                end
                if (e != 5) begin
                    model_write(a, (e == 1 || e == 3) ? 4'hF : 4'h0);
                    k++;
                end
            end
        end
        done_edge = last_rd + 2;
`ifndef BIST_ERRCNT_EN
        mec = 0;
`endif
    endtask

    task automatic do_run(input string tag, input int mid_start);
        int n, exp_done, ec, diffs;
        bit ef;
        logic [2:0] ee;
        logic [7:0] ea;
        logic [3:0] ex, eg;
        func_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_run(exp_done, ef, ee, ea, ex, eg, ec);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy_after_start"}, busy, 1);
        check({tag, ".first_we"}, sram_we, 1);
        check({tag, ".first_addr"}, sram_addr, 0);
        check({tag, ".first_din"}, sram_din, 0);
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            func_addr = 8'($urandom);
            func_din  = 4'($urandom);
            func_we   = 1'($urandom);
            start     = (n == mid_start);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        func_we = 1'b0;
        start   = 1'b0;
        check({tag, ".done_edge"}, n, exp_done);
        check({tag, ".busy_done"}, busy, 0);
        check({tag, ".fail"}, fail, ef);
        check({tag, ".fail_elem"}, fail_elem, ee);
        check({tag, ".fail_addr"}, fail_addr, ea);
        check({tag, ".fail_exp"}, fail_exp, ex);
        check({tag, ".fail_got"}, fail_got, eg);
        check({tag, ".err_count"}, err_count, ec);
        diffs = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== model_mem[a]) diffs++;
        check({tag, ".mem_diffs"}, diffs, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        func_addr = 8'h00; func_din = 4'h0; func_we = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.fail", fail, 0);
        check("rst.diag", {fail_elem, fail_addr, fail_exp, fail_got}, 0);
        check("rst.err_count", err_count, 0);
        rst = 1'b0;

        // Random power-up contents written through the functional port
        for (int a = 0; a < 256; a++) begin
            func_we = 1'b1; func_addr = a[7:0]; func_din = 4'($urandom);
            @(negedge clk);
        end
        func_we = 1'b1; func_addr = 8'h33; func_din = 4'h9;
        #1;
        check("pass.we", sram_we, 1);
        check("pass.addr", sram_addr, 8'h33);
        check("pass.din", sram_din, 4'h9);
        @(negedge clk);
        func_we = 1'b0;

        do_run("clean", -1);
        for (int a = 0; a < 256; a++) check("clean.final_zero", mem[a], 0);

        stuck_on = 1'b1; stuck_addr = 8'h5A; stuck_mask = 4'h4; stuck_val = 4'h0;
        do_run("stuck5a", -1);
        check("stuck5a.spec_elem", fail_elem, 2);
        check("stuck5a.spec_addr", fail_addr, 8'h5A);
        check("stuck5a.spec_exp", fail_exp, 4'hF);
        check("stuck5a.spec_got", fail_got, 4'hB);
`ifdef BIST_ERRCNT_EN
        check("stuck5a.spec_errcnt", err_count, 2);
`endif
        stuck_on = 1'b0;

        alias_on = 1'b1; alias_src = 8'h10; alias_dst = 8'h20;
        do_run("alias", -1);
        check("alias.spec_elem", fail_elem, 1);
        check("alias.spec_addr", fail_addr, 8'h20);
        check("alias.spec_exp", fail_exp, 4'h0);
        check("alias.spec_got", fail_got, 4'hF);
        alias_on = 1'b0;

        // Reset in the middle of M3, then a clean rerun
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (1400) @(negedge clk);
        check("m3rst.busy_before", busy, 1);
        func_we = 1'b1; func_addr = 8'($urandom); func_din = 4'($urandom);
        rst = 1'b1;
        #1;
        check("m3rst.busy", busy, 0);
        check("m3rst.done", done, 0);
        check("m3rst.fail", fail, 0);
        check("m3rst.we_pass", sram_we, 1);
        check("m3rst.addr_pass", sram_addr, func_addr);
        @(negedge clk);
        rst = 1'b0;
        func_we = 1'b0;
        do_run("after_rst", -1);

        do_run("start_in_m1", 300);

        for (int r = 0; r < 2; r++) begin
            stuck_on = 1'b1; stuck_addr = 8'($urandom);
            stuck_mask = 4'b0001 << ($urandom % 4); stuck_val = 4'($urandom);
            do_run("rand_stuck", -1);
        end
        stuck_on = 1'b0;

        alias_on = 1'b1; alias_src = 8'($urandom);
        alias_dst = alias_src ^ 8'(1 + $urandom % 255);
        do_run("rand_alias", -1);
        alias_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/march_bist_ctrl.md
Name: march_bist_ctrl

Overview:
- March C- BIST controller for the 256x4 synchronous single-port SRAM.
- On a start pulse it takes ownership of the SRAM port, runs six march elements, compares read data and reports pass/fail with diagnostics.
- When idle or done, the functional port passes straight through to the SRAM.

Parameters:
- ADDR_W, 8, SRAM address width (depth = 2^ADDR_W).
- DATA_W, 4, SRAM word width. Background 0 = all zeros; background 1 = all ones.

Ports:
- clk  in  1  rising-edge clock, shared with the SRAM.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to run the test. Sampled only in IDLE or DONE.
- func_addr  in  ADDR_W  functional address, passed through when not busy.
- func_din  in  DATA_W  functional write data.
- func_we  in  1  functional write enable.
- sram_addr  out  ADDR_W  to SRAM Address.
- sram_din  out  DATA_W  to SRAM data_in.
- sram_we  out  1  to SRAM WE.
- sram_dout  in  DATA_W  from SRAM data_out. Registered; valid the cycle after a WE=0 access.
- busy  out  1  high while the test owns the SRAM.
- done  out  1  test finished. Sticky until the next start or rst.
- fail  out  1  at least one mismatch seen. Valid when done=1.
- fail_elem  out  3  march element index (0-5) of the first mismatch.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_exp  out  DATA_W  expected word at the first mismatch.
- fail_got  out  DATA_W  read word at the first mismatch.
- err_count  out  ADDR_W+1  mismatch count. Reads 0 unless the macro is defined.

Behaviour:
- Reset (async): state=IDLE; busy, done, fail = 0; fail_elem, fail_addr, fail_exp, fail_got, err_count = 0; address counter = 0; phase = 0; compare-pending = 0.
- SRAM mux: busy=0 -> sram_* = func_*. busy=1 -> sram_* driven from the BIST registers (addr counter, phase, element), at most one decode level. func_* are ignored while busy.
- States: IDLE, M0..M5, DRAIN, DONE.
- start in IDLE or DONE -> at that edge: clear done, fail, diagnostics and err_count; addr=0; enter M0; busy=1.
- start in any other state is ignored.
- Elements (U = address 0->255, D = 255->0):
  - M0 U(w0)
  - M1 U(r0,w1)
  - M2 U(r1,w0)
  - M3 D(r0,w1)
  - M4 D(r1,w0)
  - M5 D(r0)
- Single-op elements (M0, M5): one address per cycle.
- Read-write elements (M1-M4): phase 0 = read (WE=0) at addr; phase 1 = write (WE=1) at the same addr. Addr steps after phase 1. Two cycles per address.
- Compare pipeline:
  - A read issued in cycle t sets compare-pending with the expected word and element/addr tags.
  - In cycle t+1, sram_dout is compared against the expected word; a mismatch is acted on at the end of t+1.
  - In RW elements the compare overlaps the write phase.
- Terminal address: 255 for U elements, 0 for D elements. On the terminal op, advance to the next element.
  - Addr loads 0 when the next element is U.
  - Addr loads 255 when the next element is D (M2->M3 loads 255).
- After M5's final read (addr 0), go to DRAIN for one cycle (WE=0) to perform the last compare, then enter DONE.
- Cycle budget:
  - Op cycles = 256 + 4x512 + 256 = 2560.
  - Fault-free run: done rises at the 2561st edge after the edge that sampled start.
- First mismatch (macro undefined):
  - Capture fail_elem, fail_addr, fail_exp, fail_got; set fail=1.
  - At the same edge go to DONE; busy=0, done=1.
  - The write op being issued in that cycle still completes. No further SRAM ops are issued.
- DONE: sram_* follow func_*; outputs hold until start or rst.
- rst asserted mid-test: immediate return to IDLE. sram_we follows func_we combinationally; no partial result is retained.

Optional Feature:
- Macro: BIST_ERRCNT_EN.
- Defined:
  - A mismatch does not abort the test; the full 2561-cycle sequence always runs.
  - err_count increments by 1 per mismatching read and saturates at 2^(ADDR_W+1)-1.
  - fail and the fail_* diagnostics capture the first mismatch only.
- Undefined:
  - The test aborts on the first mismatch.
  - err_count is tied to 0 and the counter logic is absent.

Test Plan:
- Fault-free SRAM, rst then 1-cycle start -> busy=1 next cycle; done=1 exactly 2561 edges after start; fail=0; final SRAM contents all 4'h0.
- Bit 2 stuck-at-0 at 0x5A -> fail=1, fail_elem=2, fail_addr=0x5A, fail_exp=4'hF, fail_got=4'hB; done one edge after the compare cycle; busy=0.
- Decoder alias (a write to 0x10 also writes 0x20) -> fail=1, fail_elem=1, fail_addr=0x20, fail_exp=4'h0, fail_got=4'hF.
- rst pulse during M3 -> busy, done, fail = 0 immediately; a following start runs the full test with done at 2561 edges and fail=0.
- busy=0, func_we=1, func_addr=0x33, func_din=4'h9 -> sram_we=1, sram_addr=0x33, sram_din=4'h9. A start pulse during M1 -> no restart; done still at 2561 edges from the original start.
- BIST_ERRCNT_EN defined, same stuck-at-0 fault at 0x5A -> run completes in 2561 edges; err_count=2 (from M2 and M4); first-fail diagnostics as in scenario 2.
